// File: rtl/iob_axi_ram_responder_if.sv
// AXI4 bus bundle between the SoC external-memory master and the RAM responder.
// Lock, cache, prot and qos are intentionally absent.
interface iob_axi_ram_responder_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 14,
    parameter int AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [AXI_LEN_W-1:0]    awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [AXI_LEN_W-1:0]    arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/iob_axi_ram_responder.sv
// AXI4 responder backed by a dual-ported byte-enabled RAM; one burst in flight per direction.
// Define IOB_AXI_RAM_RESP_WRAP_EN to support WRAP bursts (otherwise they complete with SLVERR and no data).
module iob_axi_ram_responder #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 14,
    parameter int AXI_DATA_W = 32
) (
    input logic                    clk_i,
    input logic                    arstn_i,
    iob_axi_ram_responder_if.slave axi
);
    localparam int NB     = AXI_DATA_W / 8;
    localparam int SIZE_W = $clog2(NB);
    localparam int IDX_W  = AXI_ADDR_W - SIZE_W;
    localparam int WORDS  = 2 ** IDX_W;

`ifdef IOB_AXI_RAM_RESP_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [AXI_ADDR_W-1:0] align_addr(input logic [AXI_ADDR_W-1:0] addr);
        return addr & ~AXI_ADDR_W'(NB - 1);
    endfunction

    // WRAP uses a power-of-two window of (len+1) beats; the increment carries only inside the window.
    function automatic logic [AXI_ADDR_W-1:0] next_addr(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_LEN_W-1:0]  len,
        input logic [1:0]            burst
    );
        logic [AXI_ADDR_W-1:0] incr;
        logic [AXI_ADDR_W-1:0] mask;
        incr = addr + AXI_ADDR_W'(NB);
        mask = AXI_ADDR_W'(((32'(len) + 32'd1) << SIZE_W) - 32'd1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = WRAP_EN ? ((addr & ~mask) | (incr & mask)) : incr;
            default:     next_addr = incr;
        endcase
    endfunction

    function automatic logic [1:0] burst_resp(input logic [1:0] burst);
        case (burst)
            BURST_WRAP: burst_resp = WRAP_EN ? RESP_OKAY : RESP_SLVERR;
            BURST_RSVD: burst_resp = RESP_SLVERR;
            default:    burst_resp = RESP_OKAY;
        endcase
    endfunction

    function automatic logic burst_suppress(input logic [1:0] burst);
        return (burst == BURST_WRAP) && !WRAP_EN;
    endfunction

    logic [AXI_DATA_W-1:0] mem_r [WORDS];

    w_state_t              w_state_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [AXI_ID_W-1:0]   bid_r;
    logic [1:0]            bresp_r;
    logic [AXI_ADDR_W-1:0] waddr_r;
    logic [AXI_LEN_W-1:0]  wlen_r;
    logic [AXI_LEN_W-1:0]  wcnt_r;
    logic [1:0]            wburst_r;
    logic                  wsup_r;

    r_state_t              r_state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [AXI_ID_W-1:0]   rid_r;
    logic [1:0]            rresp_r;
    logic [AXI_DATA_W-1:0] rdata_r;
    logic [AXI_ADDR_W-1:0] raddr_r;
    logic [AXI_LEN_W-1:0]  rlen_r;
    logic [AXI_LEN_W-1:0]  rcnt_r;
    logic [1:0]            rburst_r;
    logic                  rsup_r;

    logic                  aw_fire_s;
    logic                  w_fire_s;
    logic                  b_fire_s;
    logic                  ar_fire_s;
    logic                  r_fire_s;
    logic [AXI_ADDR_W-1:0] ar_base_s;
    logic                  unused_s;

    assign aw_fire_s = axi.awvalid && awready_r;
    assign w_fire_s  = axi.wvalid && wready_r;
    assign b_fire_s  = bvalid_r && axi.bready;
    assign ar_fire_s = axi.arvalid && arready_r;
    assign r_fire_s  = rvalid_r && axi.rready;
    assign ar_base_s = align_addr(axi.araddr);

    // Size is implied by the data width and wlast never ends a burst, so these are not consumed.
    assign unused_s = &{1'b0, axi.awsize, axi.arsize, axi.wlast};

    assign axi.awready = awready_r;
    assign axi.wready  = wready_r;
    assign axi.bvalid  = bvalid_r;
    assign axi.bid     = bid_r;
    assign axi.bresp   = bresp_r;
    assign axi.arready = arready_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rlast   = rlast_r;
    assign axi.rid     = rid_r;
    assign axi.rresp   = rresp_r;
    assign axi.rdata   = rdata_r;

    // Write FSM: AW capture, W beat counting, B response hold.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
            waddr_r   <= '0;
            wlen_r    <= '0;
            wcnt_r    <= '0;
            wburst_r  <= BURST_FIXED;
            wsup_r    <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_fire_s) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        bid_r     <= axi.awid;
                        bresp_r   <= burst_resp(axi.awburst);
                        waddr_r   <= align_addr(axi.awaddr);
                        wlen_r    <= axi.awlen;
                        wcnt_r    <= '0;
                        wburst_r  <= axi.awburst;
                        wsup_r    <= burst_suppress(axi.awburst);
                        w_state_r <= W_DATA;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        waddr_r <= next_addr(waddr_r, wlen_r, wburst_r);
                        wcnt_r  <= wcnt_r + AXI_LEN_W'(1);
                        if (wcnt_r == wlen_r) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire_s) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_fire_s && !wsup_r) begin
            for (int b = 0; b < NB; b++) begin
                if (axi.wstrb[b]) begin
                    mem_r[waddr_r[AXI_ADDR_W-1:SIZE_W]][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: beat 0 is fetched at the AR handshake, later beats on each R handshake.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
            raddr_r   <= '0;
            rlen_r    <= '0;
            rcnt_r    <= '0;
            rburst_r  <= BURST_FIXED;
            rsup_r    <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rlast_r   <= (axi.arlen == '0);
                        rid_r     <= axi.arid;
                        rresp_r   <= burst_resp(axi.arburst);
                        rdata_r   <= burst_suppress(axi.arburst) ? '0 : mem_r[ar_base_s[AXI_ADDR_W-1:SIZE_W]];
                        raddr_r   <= next_addr(ar_base_s, axi.arlen, axi.arburst);
                        rlen_r    <= axi.arlen;
                        rcnt_r    <= '0;
                        rburst_r  <= axi.arburst;
                        rsup_r    <= burst_suppress(axi.arburst);
                        r_state_r <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire_s) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r <= rsup_r ? '0 : mem_r[raddr_r[AXI_ADDR_W-1:SIZE_W]];
                            raddr_r <= next_addr(raddr_r, rlen_r, rburst_r);
                            rcnt_r  <= rcnt_r + AXI_LEN_W'(1);
                            rlast_r <= ((rcnt_r + AXI_LEN_W'(1)) == rlen_r);
                        end
                    end
                end
                default: begin
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end
endmodule
